// File: rtl/out_uart_tx.sv
// out_uart_tx: buffered serial transmitter for the core output port.
// Each 16-bit word leaves as two 8N1 frames, high byte first.
module out_uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          out_en,
   input  logic [15:0]                   out_dat,
   input  logic                          is_halt,
   output logic                          txd,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          drained
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t           state_q;
   logic [BW-1:0]    baud_q;
   logic [2:0]       bit_idx_q;
   logic             byte_sel_q;
   logic [15:0]      hold_q;
   logic             txd_q;

   logic [15:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;

   logic             empty;
   logic             full;
   logic             baud_done;
   logic             pop;
   logic             push;
   logic [15:0]      head;
   logic [7:0]       cur_byte;
   logic [2:0]       nxt_idx;

   assign empty     = (count_q == '0);
   assign full      = (count_q == FULL_CNT);
   assign baud_done = (baud_q == '0);
   assign head      = mem[rd_ptr_q];
   assign cur_byte  = byte_sel_q ? hold_q[7:0] : hold_q[15:8];
   assign nxt_idx   = bit_idx_q + 3'd1;

   // Words are taken from the FIFO when idle or at the end of a low-byte stop bit.
   assign pop  = !empty &&
                 ((state_q == IDLE) ||
                  ((state_q == STOP) && baud_done && byte_sel_q));
   // A full FIFO can still accept a word when the head leaves in the same cycle.
   assign push = out_en && (!full || pop);

   // FIFO pointer, occupancy and sticky overflow next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q | (out_en & ~push);
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO bookkeeping registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // FIFO storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= out_dat;
      end
   end

   // Serializer: start, 8 data bits LSB first, stop; two frames per word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_idx_q  <= '0;
         byte_sel_q <= 1'b0;
         hold_q     <= '0;
         txd_q      <= 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               txd_q <= 1'b1;
               if (pop) begin
                  hold_q     <= head;
                  byte_sel_q <= 1'b0;
                  baud_q     <= BAUD_MAX;
                  txd_q      <= 1'b0;
                  state_q    <= START;
               end
            end
            START: begin
               if (baud_done) begin
                  baud_q    <= BAUD_MAX;
                  bit_idx_q <= '0;
                  txd_q     <= cur_byte[0];
                  state_q   <= DATA;
               end else begin
                  baud_q <= baud_q - BW'(1);
               end
            end
            DATA: begin
               if (baud_done) begin
                  baud_q <= BAUD_MAX;
                  if (bit_idx_q == 3'd7) begin
                     txd_q   <= 1'b1;
                     state_q <= STOP;
                  end else begin
                     bit_idx_q <= nxt_idx;
                     txd_q     <= cur_byte[nxt_idx];
                  end
               end else begin
                  baud_q <= baud_q - BW'(1);
               end
            end
            STOP: begin
               if (baud_done) begin
                  baud_q <= BAUD_MAX;
                  if (!byte_sel_q) begin
                     byte_sel_q <= 1'b1;
                     txd_q      <= 1'b0;
                     state_q    <= START;
                  end else if (pop) begin
                     hold_q     <= head;
                     byte_sel_q <= 1'b0;
                     txd_q      <= 1'b0;
                     state_q    <= START;
                  end else begin
                     txd_q   <= 1'b1;
                     state_q <= IDLE;
                  end
               end else begin
                  baud_q <= baud_q - BW'(1);
               end
            end
            default: begin
               txd_q   <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign txd        = txd_q;
   assign busy       = !empty || (state_q != IDLE);
   assign overflow   = ovf_q;
   assign fifo_count = count_q;
   assign drained    = is_halt && !busy;

endmodule

// File: tb/tb_out_uart_tx.sv
// tb_out_uart_tx: randomized bench for out_uart_tx against a
// per-word timeline model of the serial line and FIFO occupancy.
module tb_out_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int WORD  = 20 * CPB;

   logic                        clk;
   logic                        reset;
   logic                        out_en;
   logic [15:0]                 out_dat;
   logic                        is_halt;
   logic                        txd;
   logic                        busy;
   logic                        overflow;
   logic [$clog2(DEPTH):0]      fifo_count;
   logic                        drained;

   out_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .out_en    (out_en),
      .out_dat   (out_dat),
      .is_halt   (is_halt),
      .txd       (txd),
      .busy      (busy),
      .overflow  (overflow),
      .fifo_count(fifo_count),
      .drained   (drained)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: queue of accepted words, the word on the line and
   // the number of cycles left in its 20-bit-period transmission.
   logic [15:0] m_q[$];
   logic [15:0] m_cur;
   int          m_left;
   bit          m_ovf;
   int          m_old;
   bit          m_pop;
   bit          m_acc;
   int          m_el;
   int          m_bit;
   int          m_pos;
   logic [7:0]  m_byte;
   logic        m_txd;
   logic        m_busy;
   int          peak;

   initial begin
      m_left = 0;
      m_ovf  = 0;
      m_cur  = '0;
      peak   = 0;
   end

   always @(posedge clk) begin
      if (!reset) begin
         m_q.delete();
         m_left = 0;
         m_ovf  = 0;
      end else begin
         m_old = m_q.size();
         m_pop = (m_old > 0) && (m_left <= 1);
         if (m_pop) begin
            m_cur  = m_q.pop_front();
            m_left = WORD;
         end else if (m_left > 0) begin
            m_left--;
         end
         m_acc = out_en && ((m_old < DEPTH) || m_pop);
         if (m_acc) m_q.push_back(out_dat);
         if (out_en && !m_acc) m_ovf = 1;
         #1;
         if (m_left == 0) begin
            m_txd = 1'b1;
         end else begin
            m_el   = WORD - m_left;
            m_bit  = m_el / CPB;
            m_pos  = m_bit % 10;
            m_byte = (m_bit < 10) ? m_cur[15:8] : m_cur[7:0];
            if (m_pos == 0)      m_txd = 1'b0;
            else if (m_pos == 9) m_txd = 1'b1;
            else                 m_txd = m_byte[m_pos-1];
         end
         m_busy = (m_q.size() > 0) || (m_left > 0);
         chk("txd", txd, m_txd);
         chk("busy", busy, m_busy);
         chk("fifo_count", fifo_count, m_q.size());
         chk("overflow", overflow, m_ovf);
         chk("drained", drained, is_halt && !m_busy);
         if (int'(fifo_count) > peak) peak = int'(fifo_count);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_word(input logic [15:0] w);
      @(negedge clk);
      out_en  = 1'b1;
      out_dat = w;
      @(negedge clk);
      out_en  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      idle(2);
      reset = 1'b1;
   endtask

   int n;

   initial begin
      reset   = 1'b0;
      out_en  = 1'b0;
      out_dat = '0;
      is_halt = 1'b0;
      idle(3);
      #1;
      chk("rst_txd", txd, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_drained_lo", drained, 0);
      is_halt = 1'b1;
      #1;
      chk("rst_drained_hi", drained, 1);
      is_halt = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      // Single word: start latency and 80-cycle busy window.
      @(negedge clk);
      out_en  = 1'b1;
      out_dat = 16'hA55A;
      @(negedge clk);
      out_en  = 1'b0;
      n = 0;
      while (txd !== 1'b0 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("t1_start_latency", n, 1);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("t1_busy_len", n, WORD);
      idle(5);

      // Overflow: six pushes on consecutive cycles into a 4-deep FIFO.
      peak = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         out_en  = 1'b1;
         out_dat = 16'($urandom);
      end
      @(negedge clk);
      out_en = 1'b0;
      chk("t2_overflow", overflow, 1);
      chk("t2_peak", peak, DEPTH);
      idle(5 * WORD + 10);
      chk("t2_idle", busy, 0);
      do_reset();
      #1;
      chk("t2_ovf_cleared", overflow, 0);

      // Back-to-back words.
      @(negedge clk);
      out_en  = 1'b1;
      out_dat = 16'h0001;
      @(negedge clk);
      out_dat = 16'hFF00;
      @(negedge clk);
      out_en = 1'b0;
      idle(2 * WORD + 10);
      chk("t3_idle", busy, 0);

      // Pointer wrap: spaced pushes that never fill the FIFO.
      for (int i = 0; i < 10; i++) begin
         push_word(16'($urandom));
         idle($urandom_range(70, 130));
      end
      idle(3 * WORD);
      chk("t4_no_ovf", overflow, 0);
      chk("t4_empty", fifo_count, 0);

      // Reset in the middle of the first data byte.
      push_word(16'($urandom));
      idle(4 * CPB);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("t5_txd", txd, 1);
      chk("t5_count", fifo_count, 0);
      chk("t5_busy", busy, 0);
      idle(2);
      reset = 1'b1;
      push_word(16'h1234);
      idle(WORD + 10);
      chk("t5_done", busy, 0);

      // Drain: halt raised together with the last word.
      push_word(16'($urandom));
      idle(5);
      @(negedge clk);
      is_halt = 1'b1;
      out_en  = 1'b1;
      out_dat = 16'($urandom);
      @(negedge clk);
      out_en = 1'b0;
      #1;
      chk("t6_not_drained", drained, 0);
      n = 0;
      while (drained !== 1'b1 && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("t6_drained", drained, 1);
      chk("t6_txd_idle", txd, 1);
      chk("t6_count", fifo_count, 0);
      @(negedge clk);
      is_halt = 1'b0;

      // Random bursts, overflow allowed and predicted by the model.
      repeat (6) begin
         n = $urandom_range(1, 7);
         for (int i = 0; i < n; i++) begin
            @(negedge clk);
            out_en  = ($urandom_range(0, 3) != 0);
            out_dat = 16'($urandom);
         end
         @(negedge clk);
         out_en = 1'b0;
         idle($urandom_range(0, 300));
      end
      idle((DEPTH + 2) * WORD);
      chk("t7_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
